// File: rtl/gerador_vga.sv
// VGA timing generator: pixel-tick divider, h/v counters, troca toggle and registered DAC outputs.
// Latency: RGB/sync/blank lag the counters by one pixel tick; no backpressure, free-running.
module gerador_vga #(
  parameter int CLK_DIV      = 2,
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int TROCA_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       pixel_en,
  output logic       active,
  output logic       frame_start,
  output logic       troca,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int FC_W    = (TROCA_FRAMES > 1) ? $clog2(TROCA_FRAMES) : 1;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(TROCA_FRAMES - 1);

  logic [DIV_W-1:0] div;
  logic [FC_W-1:0]  fc;
  logic             hs_raw;
  logic             vs_raw;

  // pixel_en is decoded from div one clock late, so it sits high while div==0
  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      pixel_en <= 1'b0;
    end else begin
      div      <= (div == DIV_MAX) ? '0 : div + DIV_W'(1);
      pixel_en <= (div == DIV_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_counter <= '0;
      v_counter <= '0;
    end else if (pixel_en) begin
      if (h_counter == H_MAX) begin
        h_counter <= '0;
        v_counter <= (v_counter == V_MAX) ? '0 : v_counter + 10'd1;
      end else begin
        h_counter <= h_counter + 10'd1;
      end
    end
  end

  assign frame_start = pixel_en && (h_counter == H_MAX) && (v_counter == V_MAX);
  assign active      = (h_counter < H_VIS) && (v_counter < V_VIS);
  assign hs_raw      = !((h_counter >= HS_FIRST) && (h_counter <= HS_LAST));
  assign vs_raw      = !((v_counter >= VS_FIRST) && (v_counter <= VS_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      fc    <= '0;
      troca <= 1'b0;
    end else if (frame_start) begin
      if (fc == FC_MAX) begin
        fc    <= '0;
        troca <= ~troca;
      end else begin
        fc <= fc + FC_W'(1);
      end
    end
  end

  // Sync and blank are registered with the pixel data so all DAC pins stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pixel_en) begin
      VGA_R       <= active ? R_in : 8'd0;
      VGA_G       <= active ? G_in : 8'd0;
      VGA_B       <= active ? B_in : 8'd0;
      VGA_HS      <= hs_raw;
      VGA_VS      <= vs_raw;
      VGA_BLANK_N <= active;
    end
  end

  assign VGA_SYNC_N = 1'b0;
  assign VGA_CLK    = (div >= DIV_HALF);

endmodule
